// File: rtl/mem_load_unit.sv
// Shared load sequencer: direct or one-level indirect RAM read, then one register write strobe.
// Build option: define LOAD_FLAGS_EN to add the registered o_flag_zero / o_flag_neg outputs.
module mem_load_unit #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int NUM_REGS    = 4,
  parameter int RAM_LATENCY = 1
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  input  logic                        i_indirect,
  input  logic [ADDR_WIDTH-1:0]       i_addr,
  input  logic [$clog2(NUM_REGS)-1:0] i_dest_sel,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_err,
  output logic                        o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0]       o_mem_addr,
  input  logic [DATA_WIDTH-1:0]       i_mem_rdata,
`ifdef LOAD_FLAGS_EN
  output logic                        o_flag_zero,
  output logic                        o_flag_neg,
`endif
  output logic                        o_reg_we,
  output logic [$clog2(NUM_REGS)-1:0] o_reg_sel,
  output logic [DATA_WIDTH-1:0]       o_reg_wdata
);

  localparam int SW = $clog2(NUM_REGS);
  localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
  localparam logic [SW:0] NREGS = (SW+1)'(NUM_REGS);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_CAP, S_WRITE, S_FAIL} state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_sel_ok;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [SW-1:0]         r_dest;
  logic [SW-1:0]         r_reg_sel;
  logic                  r_indirect;
  logic                  r_phase;
  logic [CW-1:0]         r_cnt;
  logic [DATA_WIDTH-1:0] r_data;

  assign w_sel_ok = ({1'b0, i_dest_sel} < NREGS);

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = w_sel_ok ? S_RD : S_FAIL;
      S_RD:    w_next = (RAM_LATENCY > 1) ? S_WAIT : S_CAP;
      S_WAIT:  if (r_cnt == CW'(1)) w_next = S_CAP;
      S_CAP:   w_next = (r_indirect && !r_phase) ? S_RD : S_WRITE;
      S_WRITE: w_next = S_IDLE;
      S_FAIL:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (r_state != S_IDLE);
    o_done      = (r_state == S_WRITE) || (r_state == S_FAIL);
    o_err       = (r_state == S_FAIL);
    o_mem_rd_en = (r_state == S_RD);
    o_reg_we    = (r_state == S_WRITE);
  end

  // r_addr only changes on entry to RD, so it doubles as the held RAM address.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr     <= '0;
      r_dest     <= '0;
      r_reg_sel  <= '0;
      r_indirect <= 1'b0;
      r_phase    <= 1'b0;
      r_cnt      <= '0;
      r_data     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start && w_sel_ok) begin
            r_addr     <= i_addr;
            r_dest     <= i_dest_sel;
            r_indirect <= i_indirect;
            r_phase    <= 1'b0;
          end
        end
        S_RD:   r_cnt <= CW'(RAM_LATENCY - 1);
        S_WAIT: r_cnt <= r_cnt - CW'(1);
        S_CAP: begin
          if (r_indirect && !r_phase) begin
            r_addr  <= i_mem_rdata[ADDR_WIDTH-1:0];
            r_phase <= 1'b1;
          end else begin
            r_data    <= i_mem_rdata;
            r_reg_sel <= r_dest;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_mem_addr  = r_addr;
  assign o_reg_sel   = r_reg_sel;
  assign o_reg_wdata = r_data;

`ifdef LOAD_FLAGS_EN
  logic r_flag_zero;
  logic r_flag_neg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_flag_zero <= 1'b0;
      r_flag_neg  <= 1'b0;
    end else if (r_state == S_WRITE) begin
      r_flag_zero <= (r_data == '0);
      r_flag_neg  <= r_data[DATA_WIDTH-1];
    end
  end

  assign o_flag_zero = r_flag_zero;
  assign o_flag_neg  = r_flag_neg;
`endif

endmodule

// File: tb/tb_mem_load_unit.sv
// Scoreboard bench for mem_load_unit: three instances (default, RAM_LATENCY=3, NUM_REGS=3).
module tb_mem_load_unit;

  typedef struct {int inst; int due; logic [3:0] addr;} rd_t;
  typedef struct {int inst; int due; logic [1:0] sel; logic [7:0] dat; logic err;} wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start [3];
  logic       ind = 1'b0;
  logic [3:0] addr = '0;
  logic [1:0] sel = '0;
  logic       busy [3], done [3], err [3], rd_en [3], we [3], fz [3], fn [3];
  logic [3:0] maddr [3];
  logic [7:0] mrdata [3];
  logic [1:0] rsel [3];
  logic [7:0] wdata [3];
  logic [7:0] ram [3][16];

  rd_t  rq[$];
  wr_t  wq[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic ez [3];
  logic en [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 1) ? 3 : 1;
    logic [7:0] pipe [LAT];

    mem_load_unit #(.RAM_LATENCY(LAT), .NUM_REGS((g == 2) ? 3 : 4)) u_dut (
      .i_clk(clk), .i_reset(rst), .i_start(start[g]), .i_indirect(ind),
      .i_addr(addr), .i_dest_sel(sel), .o_busy(busy[g]), .o_done(done[g]),
      .o_err(err[g]), .o_mem_rd_en(rd_en[g]), .o_mem_addr(maddr[g]),
      .i_mem_rdata(mrdata[g]),
`ifdef LOAD_FLAGS_EN
      .o_flag_zero(fz[g]), .o_flag_neg(fn[g]),
`endif
      .o_reg_we(we[g]), .o_reg_sel(rsel[g]), .o_reg_wdata(wdata[g])
    );

`ifndef LOAD_FLAGS_EN
    assign fz[g] = 1'b0;
    assign fn[g] = 1'b0;
`endif

    // RAM model: data only valid exactly LAT cycles after the read strobe.
    always @(posedge clk) begin
      pipe[0] <= (rd_en[g] === 1'b1) ? ram[g][maddr[g]] : 8'hEE;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mrdata[g] = pipe[LAT-1];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic int nregs(input int i);
    return (i == 2) ? 3 : 4;
  endfunction

  // Monitor: every strobe must match the head of the matching scoreboard queue.
  always @(negedge clk) begin
    rd_t r;
    wr_t w;
    for (int i = 0; i < 3; i++) begin
      if (rd_en[i] === 1'b1) begin
        if (rq.size() == 0 || rq[0].inst != i) check("rd_unexpected", rd_en[i], 0);
        else begin
          r = rq.pop_front();
          check("rd_cycle", cyc, r.due);
          check("rd_addr", maddr[i], r.addr);
        end
      end
      if (we[i] === 1'b1 && done[i] !== 1'b1) check("we_without_done", we[i], 0);
      if (done[i] === 1'b1) begin
        if (wq.size() == 0 || wq[0].inst != i) check("done_unexpected", done[i], 0);
        else begin
          w = wq.pop_front();
          check("done_cycle", cyc, w.due);
          check("err", err[i], w.err);
          check("reg_we", we[i], !w.err);
          if (w.err) check("fail_rd_en", rd_en[i], 0);
          else begin
            check("reg_sel", rsel[i], w.sel);
            check("reg_wdata", wdata[i], w.dat);
          end
        end
      end
    end
  end

  // Pushes expectations, pulses start for one cycle; returns at the next negedge.
  task automatic issue(input int i, input logic ind_v, input logic [3:0] a,
                       input logic [1:0] s, output int doff);
    rd_t r;
    wr_t w;
    logic [3:0] p;
    logic [7:0] d;
    int t0;
    int l;
    t0 = cyc;
    l = lat(i);
    w.inst = i;
    w.sel = s;
    if (int'(s) >= nregs(i)) begin
      doff = 1;
      w.dat = 8'h00;
      w.err = 1'b1;
    end else begin
      r.inst = i; r.due = t0 + 1; r.addr = a;
      rq.push_back(r);
      if (ind_v) begin
        p = ram[i][a][3:0];
        r.due = t0 + 2 + l; r.addr = p;
        rq.push_back(r);
        d = ram[i][p];
        doff = 3 + 2 * l;
      end else begin
        d = ram[i][a];
        doff = 2 + l;
      end
      w.dat = d;
      w.err = 1'b0;
      ez[i] = (d == 8'h00);
      en[i] = d[7];
    end
    w.due = t0 + doff;
    wq.push_back(w);
    ind = ind_v; addr = a; sel = s; start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  // One complete load with busy checked every cycle up to the cycle after done.
  task automatic run(input int i, input logic ind_v, input logic [3:0] a, input logic [1:0] s);
    int doff;
    issue(i, ind_v, a, s, doff);
    for (int c = 1; c <= doff + 1; c++) begin
      check("busy", busy[i], (c <= doff));
      if (c <= doff) @(negedge clk);
    end
`ifdef LOAD_FLAGS_EN
    check("flag_zero", fz[i], ez[i]);
    check("flag_neg", fn[i], en[i]);
`endif
    check("wq_pending", wq.size(), 0);
    check("rq_pending", rq.size(), 0);
  endtask

  task automatic check_zero(input int i);
    check("z_busy", busy[i], 0);
    check("z_done", done[i], 0);
    check("z_err", err[i], 0);
    check("z_rd_en", rd_en[i], 0);
    check("z_mem_addr", maddr[i], 0);
    check("z_reg_we", we[i], 0);
    check("z_reg_sel", rsel[i], 0);
    check("z_reg_wdata", wdata[i], 0);
`ifdef LOAD_FLAGS_EN
    check("z_flag_zero", fz[i], 0);
    check("z_flag_neg", fn[i], 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int doff;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      ez[i] = 1'b0;
      en[i] = 1'b0;
      for (int k = 0; k < 16; k++) ram[i][k] = 8'(k * 37 + i * 11 + 1);
    end
    ram[0][5] = 8'h11; ram[0][2] = 8'h3C; ram[0][12] = 8'h80;
    ram[0][9] = 8'h7E; ram[0][6] = 8'hC3; ram[0][1] = 8'h55;
    ram[1][0] = 8'h00; ram[1][7] = 8'hF9; ram[1][9] = 8'h5A;
    ram[2][4] = 8'h80; ram[2][8] = 8'h00;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_zero(i);
    rst = 1'b0;
    @(negedge clk);

    run(0, 1'b0, 4'h5, 2'd1);   // direct
    run(0, 1'b1, 4'h2, 2'd3);   // indirect, pointer 0x3C wraps to 0xC
    run(1, 1'b0, 4'h0, 2'd2);   // latency 3, zero data
    run(1, 1'b1, 4'h7, 2'd0);   // latency 3, indirect with pointer upper bits set
    run(2, 1'b0, 4'h4, 2'd2);   // three registers, last valid index
    run(2, 1'b0, 4'h8, 2'd3);   // out-of-range dest: FAIL, flags unchanged
    run(0, 1'b0, 4'hF, 2'd0);   // back-to-back with previous instance

    // Start pulses while busy (cycles 1 and 3) are dropped; cycle 4 start is taken.
    issue(0, 1'b0, 4'h9, 2'd2, doff);
    ind = 1'b1; addr = 4'h1; sel = 2'd0; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    @(negedge clk); start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    issue(0, 1'b0, 4'h6, 2'd1, doff);
    for (int k = 0; k < 20 && wq.size() != 0; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("b2b_wq_drained", wq.size(), 0);
    check("b2b_rq_drained", rq.size(), 0);

    // Reset at cycle 2 of an indirect load abandons it.
    issue(0, 1'b1, 4'h2, 2'd3, doff);
    @(negedge clk);
    rst = 1'b1;
    rq.delete();
    wq.delete();
    for (int i = 0; i < 3; i++) begin
      ez[i] = 1'b0;
      en[i] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b0;
    check_zero(0);
    repeat (10) @(negedge clk);
    check("rst_busy_after", busy[0], 0);
    run(0, 1'b0, 4'h5, 2'd1);
    run(1, 1'b0, 4'h9, 2'd3);

    repeat (4) @(negedge clk);
    check("final_wq_empty", wq.size(), 0);
    check("final_rq_empty", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
